data_cache_ctrl: RTL

//  Direct-mapped, write-through, no-write-allocate data cache.

---
 rtl/data_cache_ctrl_if.sv | 39 +++
 rtl/data_cache_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl_if.sv
// rtl/data_cache_ctrl_if.sv - CPU-side and memory-side signal bundle for the data cache
//
// Purpose: groups the MEM-stage request/response signals, the word-serial
// memory handshake and the hit/miss counters into one bundle.
// Modports:
//   master - environment view: drives cpu_read/cpu_write/cpu_addr/cpu_wdata
//            and answers memory requests with mem_rdata/mem_ack.
//   slave  - cache view: returns cpu_rdata/cpu_ready, issues mem_read/
//            mem_write/mem_addr/mem_wdata and exports hit_count/miss_count.
interface data_cache_ctrl_if #(
    parameter int WORD_SIZE = 16
);
    logic                 cpu_read;
    logic                 cpu_write;
    logic [WORD_SIZE-1:0] cpu_addr;
    logic [WORD_SIZE-1:0] cpu_wdata;
    logic [WORD_SIZE-1:0] cpu_rdata;
    logic                 cpu_ready;
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;
    logic [15:0]          hit_count;
    logic [15:0]          miss_count;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-through no-write-allocate data cache
//
// Purpose: 4-line x 4-word data cache between the MEM stage and data memory.
// Read hits complete in the request cycle; read misses refill the whole line
// word by word, writes go straight through to memory; both stall via cpu_ready=0.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-high
//   bus    - data_cache_ctrl_if.slave: cpu_read/cpu_write/cpu_addr/cpu_wdata in,
//            cpu_rdata/cpu_ready out; mem_read/mem_write/mem_addr/mem_wdata out,
//            mem_rdata/mem_ack in; hit_count/miss_count out
module data_cache_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int INDEX_BITS  = 2,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS
) (
    input logic              clk,
    input logic              reset,
    data_cache_ctrl_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t state, state_next;

    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [WORD_SIZE-1:0] data_mem [LINES][WORDS];
    logic [LINES-1:0]     valid;

    logic [OFFSET_BITS-1:0] fill_cnt;
    logic [WORD_SIZE-1:0]   req_addr;
    logic [WORD_SIZE-1:0]   req_wdata;
    logic [15:0]            hit_cnt;
    logic [15:0]            miss_cnt;
    // Set for the cycle right after a refill: the retried read hits then, but
    // it was already counted as a miss and must not also count as a hit.
    logic                   refill_done;

    logic [TAG_BITS-1:0]    cpu_tag, req_tag;
    logic [INDEX_BITS-1:0]  cpu_idx, req_idx;
    logic [OFFSET_BITS-1:0] cpu_off, req_off;
    logic                   cpu_hit, req_hit;

    logic                 do_hit, do_miss, do_capture;
    logic                 fill_ack, fill_last;
    logic                 cpu_ready_c, mem_read_c, mem_write_c;
    logic [WORD_SIZE-1:0] cpu_rdata_c, mem_addr_c, mem_wdata_c;

    assign {cpu_tag, cpu_idx, cpu_off} = bus.cpu_addr;
    assign {req_tag, req_idx, req_off} = req_addr;

    assign cpu_hit = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    assign fill_ack  = (state == FILL) && bus.mem_ack;
    assign fill_last = fill_ack && (fill_cnt == LAST_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            fill_cnt    <= '0;
            req_addr    <= '0;
            req_wdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            refill_done <= 1'b0;
        end else begin
            state       <= state_next;
            refill_done <= fill_last;
            if (do_hit) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (do_miss) begin
                miss_cnt <= miss_cnt + 16'd1;
                fill_cnt <= '0;
                req_addr <= bus.cpu_addr;
            end
            if (do_capture) begin
                req_addr  <= bus.cpu_addr;
                req_wdata <= bus.cpu_wdata;
            end
            if (fill_ack) begin
                fill_cnt <= fill_cnt + OFFSET_BITS'(1);
            end
            // The line only becomes valid once every word has arrived, so a
            // reset part-way through a fill leaves it invalid.
            if (fill_last) begin
                valid[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_ack) begin
                data_mem[req_idx][fill_cnt] <= bus.mem_rdata;
            end
            if (fill_last) begin
                tag_mem[req_idx] <= req_tag;
            end
            // Write-through, no allocate: only a line already holding the tag is updated.
            if ((state == WRITE) && bus.mem_ack && req_hit) begin
                data_mem[req_idx][req_off] <= req_wdata;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cpu_ready_c = 1'b0;
        cpu_rdata_c = '0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        do_hit      = 1'b0;
        do_miss     = 1'b0;
        do_capture  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_write) begin
                    do_capture = 1'b1;
                    state_next = WRITE;
                end else if (bus.cpu_read) begin
                    if (cpu_hit) begin
                        cpu_ready_c = 1'b1;
                        cpu_rdata_c = data_mem[cpu_idx][cpu_off];
                        do_hit      = !refill_done;
                    end else begin
                        do_miss    = 1'b1;
                        state_next = FILL;
                    end
                end else begin
                    cpu_ready_c = 1'b1;
                end
            end
            FILL: begin
                mem_read_c = 1'b1;
                mem_addr_c = {req_tag, req_idx, fill_cnt};
                if (fill_last) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                mem_write_c = 1'b1;
                mem_addr_c  = req_addr;
                mem_wdata_c = req_wdata;
                cpu_ready_c = bus.mem_ack;
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cpu_ready  = cpu_ready_c;
    assign bus.cpu_rdata  = cpu_rdata_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
endmodule
